// File: rtl/trans_mem_reader.sv
// trans_mem_reader: drains Trans_Mem1 then Trans_Mem2 onto a valid/ready stream, tagging each word
// with its source memory and index. Build macro RD_INTERLEAVE_EN alternates sources while both hold words.
module trans_mem_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   Trans_Mem1_Count,
  input  logic [ADDR_W:0]   Trans_Mem2_Count,
  input  logic [DATA_W-1:0] Trans_Mem1_Data,
  input  logic [DATA_W-1:0] Trans_Mem2_Data,
  output logic              Trans_Mem_RD_CLR,
  output logic              Trans_Mem1_RD_CNT_EN,
  output logic              Trans_Mem2_RD_CNT_EN,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Out_Src,
  output logic [ADDR_W-1:0] Out_Index,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        reader_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_PRESENT = 3'd3,
    S_ADVANCE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W:0]   MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_CNT = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_IDX = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W+1:0] ONE_SUM = {{(ADDR_W+1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic              start_q;
  logic [ADDR_W:0]   rem1, rem2;
  logic [ADDR_W-1:0] idx1, idx2;
  logic [ADDR_W:0]   snap1, snap2;
  logic [ADDR_W+1:0] rem_total;
  logic              last_word;
  logic              sel_nxt;

  function automatic logic [ADDR_W:0] sat_cnt(input logic [ADDR_W:0] cnt);
    return (cnt > MAX_CNT) ? MAX_CNT : cnt;
  endfunction

  assign snap1     = sat_cnt(Trans_Mem1_Count);
  assign snap2     = sat_cnt(Trans_Mem2_Count);
  assign rem_total = {1'b0, rem1} + {1'b0, rem2};
  assign last_word = (rem_total == ONE_SUM);

`ifdef RD_INTERLEAVE_EN
  // Toggles after every ADVANCE; only consulted while both memories still hold words.
  logic turn;

  always_ff @(posedge clock) begin
    if (!reset) begin
      turn <= 1'b0;
    end else if (state == S_CLEAR) begin
      turn <= 1'b0;
    end else if (state == S_ADVANCE) begin
      turn <= ~turn;
    end
  end

  assign sel_nxt = (rem1 != '0 && rem2 != '0) ? turn : (rem1 == '0);
`else
  assign sel_nxt = (rem1 == '0);
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_q) state_nxt = S_CLEAR;
      S_CLEAR:   state_nxt = (snap1 == '0 && snap2 == '0) ? S_DONE : S_LOAD;
      S_LOAD:    state_nxt = S_PRESENT;
      S_PRESENT: if (Out_Ready) state_nxt = S_ADVANCE;
      S_ADVANCE: state_nxt = last_word ? S_DONE : S_LOAD;
      S_DONE:    if (start_q) state_nxt = S_CLEAR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode only from the state register and the registered source tag.
  always_comb begin
    Trans_Mem_RD_CLR     = (state == S_CLEAR);
    Trans_Mem1_RD_CNT_EN = (state == S_ADVANCE) && !Out_Src;
    Trans_Mem2_RD_CNT_EN = (state == S_ADVANCE) &&  Out_Src;
    Out_Valid            = (state == S_PRESENT);
    busy                 = (state == S_CLEAR) || (state == S_LOAD) ||
                           (state == S_PRESENT) || (state == S_ADVANCE);
    done                 = (state == S_DONE);
    reader_state         = state;
  end

  // start is registered, giving a fixed one-cycle latency from the start edge to CLEAR.
  always_ff @(posedge clock) begin
    if (!reset) begin
      start_q   <= 1'b0;
      rem1      <= '0;
      rem2      <= '0;
      idx1      <= '0;
      idx2      <= '0;
      Out_Data  <= '0;
      Out_Src   <= 1'b0;
      Out_Index <= '0;
    end else begin
      start_q <= start && (state == S_IDLE || state == S_DONE);
      case (state)
        S_CLEAR: begin
          rem1 <= snap1;
          rem2 <= snap2;
          idx1 <= '0;
          idx2 <= '0;
        end
        S_LOAD: begin
          Out_Src   <= sel_nxt;
          Out_Data  <= sel_nxt ? Trans_Mem2_Data : Trans_Mem1_Data;
          Out_Index <= sel_nxt ? idx2 : idx1;
        end
        S_ADVANCE: begin
          if (Out_Src) begin
            rem2 <= rem2 - ONE_CNT;
            idx2 <= idx2 + ONE_IDX;
          end else begin
            rem1 <= rem1 - ONE_CNT;
            idx1 <= idx1 + ONE_IDX;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
